// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: Sysbus tag encoding, line size and FSM states.
package core_pkg;

   localparam int unsigned LINE_BYTES  = 64;
   localparam int unsigned FETCH_TAG_W = 13;

   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

   // Tag carried by every instruction-line read.
   localparam logic [FETCH_TAG_W-1:0] FETCH_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_RESP,
      FS_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Sysbus request/response channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
   parameter int unsigned TAG_W = 13
);
   logic             reqcyc;
   logic [63:0]      req;
   logic [TAG_W-1:0] reqtag;
   logic             reqack;
   logic             respcyc;
   logic [63:0]      resp;
   logic             respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp
   );
endinterface

// File: rtl/fetch_ring_buffer.sv
// Circular byte store: writes up to 8 bytes per cycle at a wrapping offset,
// exposes the whole ring as one flat vector for the decoder.
module fetch_ring_buffer #(
   parameter int unsigned BUF_BYTES = 128
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(BUF_BYTES)-1:0] wr_base,
   input  logic [7:0]                   wr_be,
   input  logic [63:0]                  wr_data,
   output logic [BUF_BYTES*8-1:0]       buf_data
);
   localparam int unsigned IDX_W = $clog2(BUF_BYTES);

   logic [IDX_W-1:0] wr_idx [8];

   // Byte k of the beat lands at (wr_base + k) mod BUF_BYTES, so a beat may wrap.
   always_comb begin
      for (int unsigned k = 0; k < 8; k++) begin
         wr_idx[k] = wr_base + IDX_W'(k);
      end
   end

   // Byte-enabled store into the ring.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_data <= '0;
      end else if (wr_en) begin
         for (int unsigned k = 0; k < 8; k++) begin
            if (wr_be[k]) begin
               buf_data[wr_idx[k]*8 +: 8] <= wr_data[k*8 +: 8];
            end
         end
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests 64-byte lines, trims bytes ahead of the fetch RIP,
// streams the rest into the ring buffer and restarts on redirect.
module fetch_unit #(
   parameter int unsigned BUF_BYTES  = 128,
   parameter int unsigned LINE_BYTES = core_pkg::LINE_BYTES,
   parameter int unsigned TAG_W      = core_pkg::FETCH_TAG_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [63:0]                  entry,
   input  logic                         redirect_valid,
   input  logic [63:0]                  redirect_rip,
   fetch_unit_if.master                 bus,
   output logic [BUF_BYTES*8-1:0]       buf_data,
   output logic [$clog2(BUF_BYTES):0]   wr_offset,
   input  logic [$clog2(BUF_BYTES):0]   rd_offset
);
   import core_pkg::*;

   localparam int unsigned OFF_W = $clog2(BUF_BYTES) + 1;
   localparam int unsigned IDX_W = $clog2(BUF_BYTES);
   localparam int unsigned LSB_W = $clog2(LINE_BYTES);

   fetch_state_t     state;
   logic             drop;
   logic [2:0]       beat;
   logic [63:0]      fetch_rip;
   logic [LSB_W-1:0] skip;
   logic             reqcyc;
   logic [63:0]      req;

   logic [OFF_W-1:0] occupancy;
   logic             issue_ok;
   logic             beat_live;
   logic             skip_whole;
   logic             wr_en;
   logic [7:0]       wr_be;
   logic [63:0]      wr_data;
   logic [3:0]       wr_count;

   assign bus.reqcyc  = reqcyc;
   assign bus.req     = req;
   assign bus.reqtag  = TAG_W'(FETCH_TAG);
   assign bus.respack = bus.respcyc;

   // Flow control and trimming of the current beat: skip bytes are shifted out
   // so surviving bytes always start at byte-enable bit 0.
   always_comb begin
      occupancy  = wr_offset - rd_offset;
      issue_ok   = occupancy <= OFF_W'(BUF_BYTES - LINE_BYTES);
      beat_live  = (state == FS_RESP) && bus.respcyc && !redirect_valid;
      skip_whole = skip >= LSB_W'(8);
      wr_en      = beat_live && !skip_whole;
      wr_data    = bus.resp >> {skip[2:0], 3'b000};
      wr_be      = 8'hFF >> skip[2:0];
      wr_count   = 4'd8 - {1'b0, skip[2:0]};
   end

   // Fetch FSM, skip/offset bookkeeping and request handshake; redirect is applied last so it wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FS_IDLE;
         drop      <= 1'b0;
         beat      <= '0;
         reqcyc    <= 1'b0;
         req       <= '0;
         wr_offset <= '0;
         fetch_rip <= {entry[63:LSB_W], {LSB_W{1'b0}}};
         skip      <= entry[LSB_W-1:0];
      end else begin
         if (bus.respcyc && (state == FS_RESP || state == FS_DRAIN)) begin
            beat <= beat + 3'd1;
         end

         if (beat_live) begin
            if (skip_whole) begin
               skip <= skip - LSB_W'(8);
            end else begin
               wr_offset <= wr_offset + OFF_W'(wr_count);
               skip      <= '0;
            end
         end

         case (state)
            FS_IDLE: begin
               if (!redirect_valid && issue_ok) begin
                  reqcyc <= 1'b1;
                  req    <= fetch_rip;
                  state  <= FS_REQ;
               end
            end
            FS_REQ: begin
               if (bus.reqack) begin
                  reqcyc <= 1'b0;
                  beat   <= '0;
                  state  <= (drop || redirect_valid) ? FS_DRAIN : FS_RESP;
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            FS_RESP: begin
               // A redirect on the final beat still ends the burst, otherwise DRAIN would wait forever.
               if (bus.respcyc && beat == 3'd7) begin
                  state     <= FS_IDLE;
                  drop      <= 1'b0;
                  fetch_rip <= fetch_rip + 64'(LINE_BYTES);
                  skip      <= '0;
               end else if (redirect_valid) begin
                  state <= FS_DRAIN;
               end
            end
            FS_DRAIN: begin
               if (bus.respcyc && beat == 3'd7) begin
                  state <= FS_IDLE;
                  drop  <= 1'b0;
               end
            end
            default: state <= FS_IDLE;
         endcase

         if (redirect_valid) begin
            fetch_rip <= {redirect_rip[63:LSB_W], {LSB_W{1'b0}}};
            skip      <= redirect_rip[LSB_W-1:0];
            wr_offset <= rd_offset;
         end
      end
   end

   // Beats are only legal while a burst is outstanding.
   assert property (@(posedge clk) disable iff (reset)
      bus.respcyc |-> (state == FS_RESP || state == FS_DRAIN))
      else $fatal(1, "fetch_unit: respcyc outside a burst");

   fetch_ring_buffer #(
      .BUF_BYTES(BUF_BYTES)
   ) u_ring (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_base  (wr_offset[IDX_W-1:0]),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
      .buf_data (buf_data)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a Sysbus memory responder, a stream-level model of the
// ring contents checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;
   localparam int unsigned BUF_BYTES = 128;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [63:0]            entry = 64'h1000;
   logic                   redirect_valid = 1'b0;
   logic [63:0]            redirect_rip = '0;
   logic [BUF_BYTES*8-1:0] buf_data;
   logic [7:0]             wr_offset;
   logic [7:0]             rd_offset = '0;

   int n_chk = 0;
   int n_fail = 0;

   fetch_unit_if #(.TAG_W(13)) bus ();

   fetch_unit #(
      .BUF_BYTES  (128),
      .LINE_BYTES (64),
      .TAG_W      (13)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .entry          (entry),
      .redirect_valid (redirect_valid),
      .redirect_rip   (redirect_rip),
      .bus            (bus),
      .buf_data       (buf_data),
      .wr_offset      (wr_offset),
      .rd_offset      (rd_offset)
   );

   always #5 clk = ~clk;

   // Memory image: low byte of the address, perturbed per 256-byte page.
   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      logic [7:0] hi;
      hi = a[15:8] - 8'h10;
      return a[7:0] + hi * 8'h61;
   endfunction

   function automatic logic [7:0] ring_byte(input int idx);
      return buf_data[idx*8 +: 8];
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- bus responder ----------------
   int          ack_delay = 0;
   int          redir_beat = -1;
   bit          redir_in_req = 1'b0;
   logic [63:0] redir_addr = '0;
   int          phase = 0;
   int          cnt = 0;
   int          beatn = 0;
   logic [63:0] raddr = '0;

   initial begin
      bus.reqack  = 1'b0;
      bus.respcyc = 1'b0;
      bus.resp    = '0;
   end

   always @(negedge clk) begin
      bus.reqack     = 1'b0;
      bus.respcyc    = 1'b0;
      redirect_valid = 1'b0;
      if (reset) begin
         phase = 0;
      end else begin
         case (phase)
            0: if (bus.reqcyc) begin
               raddr = bus.req;
               cnt   = 0;
               beatn = 0;
               if (ack_delay == 0) begin
                  bus.reqack = 1'b1;
                  phase = 2;
               end else begin
                  phase = 1;
               end
            end
            1: begin
               cnt++;
               if (redir_in_req && cnt == 2) begin
                  redirect_valid = 1'b1;
                  redirect_rip   = redir_addr;
                  redir_in_req   = 1'b0;
               end
               if (cnt >= ack_delay) begin
                  bus.reqack = 1'b1;
                  phase = 2;
               end
            end
            default: begin
               bus.respcyc = 1'b1;
               for (int k = 0; k < 8; k++) begin
                  bus.resp[k*8 +: 8] = mem_byte(raddr + 64'(8*beatn + k));
               end
               if (beatn == redir_beat) begin
                  redirect_valid = 1'b1;
                  redirect_rip   = redir_addr;
                  redir_beat     = -1;
               end
               beatn++;
               if (beatn == 8) phase = 0;
            end
         endcase
      end
   end

   // ---------------- stream model ----------------
   // Every valid ring byte at offset o holds mem[start_addr + (o - start_off)].
   logic [63:0] start_addr = '0;
   logic [7:0]  start_off = '0;
   bit          redir_edge = 1'b0;
   bit          ack_edge = 1'b0;
   bit          respcyc_edge = 1'b0;
   bit          respack_edge = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         start_addr   = entry;
         start_off    = '0;
         redir_edge   = 1'b0;
         ack_edge     = 1'b0;
         respcyc_edge = 1'b0;
         respack_edge = 1'b0;
      end else begin
         ack_edge     = bus.reqack;
         respcyc_edge = bus.respcyc;
         respack_edge = bus.respack;
         redir_edge   = redirect_valid;
         if (redirect_valid) begin
            start_addr = redirect_rip;
            start_off  = rd_offset;
         end
      end
   end

   logic [63:0] req_log[$];
   bit          prev_reqcyc = 1'b0;
   logic [63:0] prev_req = '0;
   int          hi_len = 0;
   int          last_hi_len = 0;

   always @(negedge clk) begin : compare
      int          occ;
      logic [7:0]  o;
      logic [7:0]  since;
      logic [7:0]  got;
      logic [7:0]  exp;
      logic [7:0]  got_r;
      logic [7:0]  exp_r;
      bit          bad;
      if (reset) begin
         prev_reqcyc = 1'b0;
         hi_len      = 0;
      end else begin
         if (prev_reqcyc) begin
            if (ack_edge) begin
               check("req_release", {63'd0, bus.reqcyc}, 64'd0);
            end else begin
               check("req_hold_valid", {63'd0, bus.reqcyc}, 64'd1);
               check("req_hold_addr", bus.req, prev_req);
            end
         end
         if (bus.reqcyc) begin
            check("req_align", {58'd0, bus.req[5:0]}, 64'd0);
            check("req_tag", {51'd0, bus.reqtag}, 64'h1100);
         end
         if (respcyc_edge) check("respack", {63'd0, respack_edge}, 64'd1);
         if (redir_edge) check("redirect_flush", {56'd0, wr_offset}, {56'd0, rd_offset});

         occ = int'(8'(wr_offset - rd_offset));
         if (occ > BUF_BYTES) begin
            check("occupancy", 64'(occ), 64'(BUF_BYTES));
         end else if (occ > 0) begin
            bad = 1'b0;
            got_r = '0;
            exp_r = '0;
            for (int i = 0; i < occ; i++) begin
               o     = rd_offset + 8'(i);
               since = o - start_off;
               got   = ring_byte(int'(o[6:0]));
               exp   = mem_byte(start_addr + 64'(since));
               if (!bad) begin
                  got_r = got;
                  exp_r = exp;
               end
               if (got !== exp) bad = 1'b1;
            end
            check("ring_byte", {56'd0, got_r}, {56'd0, exp_r});
         end

         if (bus.reqcyc && !prev_reqcyc) req_log.push_back(bus.req);
         if (bus.reqcyc) begin
            hi_len++;
         end else if (prev_reqcyc) begin
            last_hi_len = hi_len;
            hi_len = 0;
         end
         prev_reqcyc = bus.reqcyc;
         prev_req    = bus.req;
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic do_reset(input logic [63:0] e);
      @(negedge clk);
      entry     = e;
      rd_offset = '0;
      reset     = 1'b1;
      req_log.delete();
      repeat (2) @(negedge clk);
      check("reset_reqcyc", {63'd0, bus.reqcyc}, 64'd0);
      check("reset_req", bus.req, 64'd0);
      check("reset_wr", {56'd0, wr_offset}, 64'd0);
      check("reset_buf", {63'd0, (buf_data == '0)}, 64'd1);
      reset = 1'b0;
   endtask

   task automatic wait_wr(input string name, input logic [7:0] val, input int budget);
      int k;
      k = 0;
      while (wr_offset !== val && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, {56'd0, wr_offset}, {56'd0, val});
   endtask

   task automatic set_rd(input logic [7:0] v);
      @(posedge clk);
      #1 rd_offset = v;
   endtask

   task automatic check_log(input string name, input int idx, input logic [63:0] exp);
      if (req_log.size() > idx) check(name, req_log[idx], exp);
      else check(name, 64'(req_log.size()), 64'(idx + 1));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k;

      // Aligned entry: one-cycle request latency, in-order bytes, fill to two lines.
      ack_delay = 0;
      do_reset(64'h1000);
      @(negedge clk);
      check("first_reqcyc", {63'd0, bus.reqcyc}, 64'd1);
      check("first_req", bus.req, 64'h1000);
      wait_wr("line1_wr", 8'd64, 100);
      for (int i = 0; i < 64; i++) check("line1_byte", {56'd0, ring_byte(i)}, 64'(i));
      wait_wr("line2_wr", 8'd128, 100);
      repeat (40) @(negedge clk);
      check("full_wr", {56'd0, wr_offset}, 64'd128);
      check("full_nreq", 64'(req_log.size()), 64'd2);
      check("full_reqcyc", {63'd0, bus.reqcyc}, 64'd0);
      set_rd(8'd64);
      wait_wr("line3_wr", 8'd192, 100);
      check_log("line3_req", 2, 64'h1080);
      check("wrap_byte0", {56'd0, ring_byte(0)}, 64'h80);
      check("wrap_byte63", {56'd0, ring_byte(63)}, 64'hBF);

      // Unaligned entry: 11 leading bytes trimmed.
      do_reset(64'h100B);
      wait_wr("skip_wr", 8'd53, 100);
      check("skip_byte0", {56'd0, ring_byte(0)}, 64'h0B);
      check("skip_byte52", {56'd0, ring_byte(52)}, 64'h3F);
      wait_wr("skip_wr2", 8'd117, 100);
      check("skip_byte53", {56'd0, ring_byte(53)}, 64'h40);
      check_log("skip_req0", 0, 64'h1000);
      check_log("skip_req1", 1, 64'h1040);

      // Slow acknowledge: request held for the whole wait.
      ack_delay = 5;
      do_reset(64'h1000);
      wait_wr("slow_wr", 8'd64, 200);
      check("slow_hi_len", 64'(last_hi_len), 64'd6);
      check_log("slow_req0", 0, 64'h1000);

      // Redirect on beat 3 of the first burst.
      ack_delay  = 0;
      redir_beat = 3;
      redir_addr = 64'h2004;
      do_reset(64'h1000);
      wait_wr("redir_wr", 8'd60, 200);
      check_log("redir_req1", 1, 64'h2000);
      check("redir_byte0", {56'd0, ring_byte(0)}, 64'h14);
      wait_wr("redir_wr2", 8'd124, 200);
      check_log("redir_req2", 2, 64'h2040);
      check("redir_byte59", {56'd0, ring_byte(59)}, 64'h4F);

      // Redirect while the request waits for acknowledge.
      ack_delay    = 5;
      redir_in_req = 1'b1;
      redir_addr   = 64'h3010;
      do_reset(64'h1000);
      wait_wr("reqredir_wr", 8'd48, 300);
      check_log("reqredir_req0", 0, 64'h1000);
      check_log("reqredir_req1", 1, 64'h3000);
      check("reqredir_byte0", {56'd0, ring_byte(0)}, 64'h30);
      wait_wr("reqredir_wr2", 8'd112, 300);

      // Asynchronous reset while the second request is pending.
      ack_delay = 5;
      do_reset(64'h1000);
      k = 0;
      while (!(wr_offset == 8'd64 && bus.reqcyc) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("pre_reset_pending", {63'd0, (wr_offset == 8'd64 && bus.reqcyc)}, 64'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_reqcyc", {63'd0, bus.reqcyc}, 64'd0);
      check("async_wr", {56'd0, wr_offset}, 64'd0);
      check("async_buf", {63'd0, (buf_data == '0)}, 64'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      req_log.delete();
      wait_wr("recover_wr", 8'd64, 200);
      check_log("recover_req0", 0, 64'h1000);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
